// File: rtl/block_pixel_render_if.sv
// Pixel-render bus: VGA timing in, board memory / sprite ROM ports, RGB and delayed syncs out.
// master = environment (timing generator, memories, DAC); slave = render stage.
interface block_pixel_render_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        BLANK_N_in;
    logic        HS_in;
    logic        VS_in;
    logic [7:0]  CELL_ADDR;
    logic [1:0]  CELL_STYLE;
    logic [2:0]  CELL_PIECE;
    logic [5:0]  SPRITE_ADDR;
    logic [31:0] SPRITE_DATA;
    logic [7:0]  RED;
    logic [7:0]  GREEN;
    logic [7:0]  BLUE;
    logic        BLANK_N_out;
    logic        HS_out;
    logic        VS_out;

    // There is no valid/ready handshake: one pixel enters and one leaves on every clock,
    // and every output lags its input by a fixed four edges.
    modport master (
        output DrawX, DrawY, BLANK_N_in, HS_in, VS_in,
        input  CELL_ADDR,
        output CELL_STYLE, CELL_PIECE,
        input  SPRITE_ADDR,
        output SPRITE_DATA,
        input  RED, GREEN, BLUE, BLANK_N_out, HS_out, VS_out
    );

    modport slave (
        input  DrawX, DrawY, BLANK_N_in, HS_in, VS_in,
        output CELL_ADDR,
        input  CELL_STYLE, CELL_PIECE,
        output SPRITE_ADDR,
        input  SPRITE_DATA,
        output RED, GREEN, BLUE, BLANK_N_out, HS_out, VS_out
    );
endinterface

// File: rtl/block_pixel_render.sv
// Four-stage pixel render: screen position -> board cell -> sprite row -> palette RGB,
// with HS/VS/BLANK delayed to stay aligned with the colour.
module block_pixel_render #(
    parameter int BOARD_X0 = 240,
    parameter int BOARD_Y0 = 80,
    parameter int COLS     = 10,
    parameter int ROWS     = 20,
    parameter int CELL     = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    block_pixel_render_if.slave  bus
);
    localparam logic [10:0] X_BEG = 11'(BOARD_X0);
    localparam logic [10:0] X_END = 11'(BOARD_X0 + COLS * CELL);
    localparam logic [10:0] Y_BEG = 11'(BOARD_Y0);
    localparam logic [10:0] Y_END = 11'(BOARD_Y0 + ROWS * CELL);

    // Bounds are checked on the raw coordinates so a pixel left of / above the board
    // cannot wrap into it through the subtraction below.
    logic       w_in_board;
    logic [9:0] w_off_x;
    logic [9:0] w_off_y;
    logic [7:0] w_cell_idx;

    assign w_in_board = ({1'b0, bus.DrawX} >= X_BEG) && ({1'b0, bus.DrawX} < X_END) &&
                        ({1'b0, bus.DrawY} >= Y_BEG) && ({1'b0, bus.DrawY} < Y_END);
    assign w_off_x    = bus.DrawX - 10'(BOARD_X0);
    assign w_off_y    = bus.DrawY - 10'(BOARD_Y0);
    assign w_cell_idx = 8'(({2'b00, w_off_y[9:4]} * 8'(COLS)) + {2'b00, w_off_x[9:4]});

    // Stage 1
    logic [7:0] r_cell_addr;
    logic       r_s1_in_board, r_s1_blank_n, r_s1_hs, r_s1_vs;
    logic [3:0] r_s1_px, r_s1_py;
    // Stage 2
    logic       r_s2_in_board, r_s2_blank_n, r_s2_hs, r_s2_vs;
    logic [3:0] r_s2_px, r_s2_py;
    // Stage 3
    logic       r_s3_in_board, r_s3_blank_n, r_s3_hs, r_s3_vs;
    logic [1:0] r_s3_code;
    logic [2:0] r_s3_piece;
    // Stage 4
    logic [23:0] r_rgb;
    logic        r_blank_n_out, r_hs_out, r_vs_out;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cell_addr   <= '0;
            r_s1_in_board <= 1'b0;
            r_s1_blank_n  <= 1'b0;
            r_s1_hs       <= 1'b1;
            r_s1_vs       <= 1'b1;
            r_s1_px       <= '0;
            r_s1_py       <= '0;
        end else begin
            r_cell_addr   <= w_in_board ? w_cell_idx : 8'd0;
            r_s1_in_board <= w_in_board;
            r_s1_blank_n  <= bus.BLANK_N_in;
            r_s1_hs       <= bus.HS_in;
            r_s1_vs       <= bus.VS_in;
            r_s1_px       <= w_off_x[3:0];
            r_s1_py       <= w_off_y[3:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s2_in_board <= 1'b0;
            r_s2_blank_n  <= 1'b0;
            r_s2_hs       <= 1'b1;
            r_s2_vs       <= 1'b1;
            r_s2_px       <= '0;
            r_s2_py       <= '0;
        end else begin
            r_s2_in_board <= r_s1_in_board;
            r_s2_blank_n  <= r_s1_blank_n;
            r_s2_hs       <= r_s1_hs;
            r_s2_vs       <= r_s1_vs;
            r_s2_px       <= r_s1_px;
            r_s2_py       <= r_s1_py;
        end
    end

    // Sprite pixel 0 sits in the top two bits, so pixel px starts at bit 30-2*px.
    logic [4:0] w_bit_lo;
    logic [1:0] w_code;

    assign w_bit_lo = 5'd30 - {r_s2_px, 1'b0};
    assign w_code   = 2'(bus.SPRITE_DATA >> w_bit_lo);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s3_in_board <= 1'b0;
            r_s3_blank_n  <= 1'b0;
            r_s3_hs       <= 1'b1;
            r_s3_vs       <= 1'b1;
            r_s3_code     <= '0;
            r_s3_piece    <= '0;
        end else begin
            r_s3_in_board <= r_s2_in_board;
            r_s3_blank_n  <= r_s2_blank_n;
            r_s3_hs       <= r_s2_hs;
            r_s3_vs       <= r_s2_vs;
            r_s3_code     <= w_code;
            r_s3_piece    <= bus.CELL_PIECE;
        end
    end

    function automatic logic [23:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 24'h808080;
            3'd1:    palette = 24'h00FFFF;
            3'd2:    palette = 24'hFFFF00;
            3'd3:    palette = 24'hA000F0;
            3'd4:    palette = 24'h00F000;
            3'd5:    palette = 24'hF00000;
            3'd6:    palette = 24'h0000F0;
            default: palette = 24'hF0A000;
        endcase
    endfunction

    logic [23:0] w_base;
    logic [23:0] w_rgb_next;

    assign w_base = palette(r_s3_piece);

    // Code 01 is the shaded edge of a block: each channel halved independently.
    always_comb begin
        w_rgb_next = 24'h000000;
        if (r_s3_blank_n && r_s3_in_board) begin
            case (r_s3_code)
                2'b00:   w_rgb_next = w_base;
                2'b01:   w_rgb_next = {1'b0, w_base[23:17], 1'b0, w_base[15:9], 1'b0, w_base[7:1]};
                2'b10:   w_rgb_next = 24'h303030;
                default: w_rgb_next = 24'hFFFFFF;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rgb         <= '0;
            r_blank_n_out <= 1'b0;
            r_hs_out      <= 1'b1;
            r_vs_out      <= 1'b1;
        end else begin
            r_rgb         <= w_rgb_next;
            r_blank_n_out <= r_s3_blank_n;
            r_hs_out      <= r_s3_hs;
            r_vs_out      <= r_s3_vs;
        end
    end

    assign bus.CELL_ADDR   = r_cell_addr;
    assign bus.SPRITE_ADDR = {bus.CELL_STYLE, r_s2_py};
    assign bus.RED         = r_rgb[23:16];
    assign bus.GREEN       = r_rgb[15:8];
    assign bus.BLUE        = r_rgb[7:0];
    assign bus.BLANK_N_out = r_blank_n_out;
    assign bus.HS_out      = r_hs_out;
    assign bus.VS_out      = r_vs_out;
endmodule
